// File: rtl/cmd_ram_pkg.sv
// Shared opcodes, transmit FSM encoding and pointer arithmetic for cmd_ram_ctrl.
package cmd_ram_pkg;

  localparam logic [1:0] OP_WADDR = 2'b00;
  localparam logic [1:0] OP_WDATA = 2'b01;
  localparam logic [1:0] OP_RADDR = 2'b10;
  localparam logic [1:0] OP_RDATA = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } tx_st_e;

  // Out-of-range address payloads saturate to the last valid word.
  function automatic int unsigned clamp_addr(input int unsigned a, input int unsigned depth);
    return (a >= depth) ? depth - 1 : a;
  endfunction

  // Post-increment that wraps at the last word, so depth need not be 2**N.
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p >= depth - 1) ? 0 : p + 1;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port storage: synchronous write, registered synchronous read, no reset.
module sp_ram #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  // One access per cycle; read data only changes on a read, so it holds otherwise.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    rdata     <= mem[addr];
    end
  end

endmodule

// File: rtl/cmd_ram_ctrl.sv
// Command-driven RAM controller: decodes opcode words, owns the address
// pointers, the read-data handshake FSM and the sticky drop/clamp error flag.
module cmd_ram_ctrl
  import cmd_ram_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int AUTO_INC  = 1,
  parameter int PAY_W     = (DATA_W > ADDR_W) ? DATA_W : ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PAY_W+1:0]  din,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [DATA_W-1:0] dout,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              err_drop,
  input  logic              err_clr
);

  localparam int unsigned DEPTH_U = MEM_DEPTH;

  logic [1:0]        op;
  logic [PAY_W-1:0]  pay;
  logic [ADDR_W-1:0] pay_addr, pay_addr_c;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [DATA_W-1:0] ram_q;
  logic              acc, drop, clamp, ram_we, ram_en, rd_acc;
  tx_st_e            state_q, state_d;

  assign op         = din[PAY_W+1:PAY_W];
  assign pay        = din[PAY_W-1:0];
  assign pay_addr   = pay[ADDR_W-1:0];
  assign pay_addr_c = ADDR_W'(clamp_addr(32'(pay_addr), DEPTH_U));

  // A pending word that is not being taken this cycle stalls every opcode.
  assign tx_valid = (state_q == ST_PEND);
  assign rx_ready = !(tx_valid && !tx_ready);
  assign acc      = rx_valid && rx_ready;
  assign drop     = rx_valid && !rx_ready;
  assign rd_acc   = acc && (op == OP_RDATA);
  assign clamp    = acc && ((op == OP_WADDR) || (op == OP_RADDR)) && (32'(pay_addr) >= DEPTH_U);

  assign ram_we = acc && (op == OP_WDATA);
  assign ram_en = ram_we || rd_acc;

  // Gating by state makes dout drop to 0 the instant reset asserts.
  assign dout = tx_valid ? ram_q : '0;

  sp_ram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_we ? wr_ptr : rd_ptr),
    .wdata (pay[DATA_W-1:0]),
    .rdata (ram_q)
  );

  // Transmit state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state: a read accepted while the current word leaves keeps us in PEND.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (rd_acc) state_d = ST_PEND;
      ST_PEND: if (tx_ready && !rd_acc) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Address pointers: loaded by address ops, optionally bumped by data ops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (acc) begin
      case (op)
        OP_WADDR: wr_ptr <= pay_addr_c;
        OP_WDATA: if (AUTO_INC != 0) wr_ptr <= ADDR_W'(wrap_inc(32'(wr_ptr), DEPTH_U));
        OP_RADDR: rd_ptr <= pay_addr_c;
        OP_RDATA: if (AUTO_INC != 0) rd_ptr <= ADDR_W'(wrap_inc(32'(rd_ptr), DEPTH_U));
        default: ;
      endcase
    end
  end

  // Sticky error: a new drop or clamp beats a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                err_drop <= 1'b0;
    else if (drop || clamp) err_drop <= 1'b1;
    else if (err_clr)       err_drop <= 1'b0;
  end

endmodule

// File: tb/tb_cmd_ram_ctrl.sv
// Bench for cmd_ram_ctrl: directed scenarios plus random traffic against a
// behavioural model (memory array, pointers, one pending-word slot, error flag).
module tb_cmd_ram_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 8;
  localparam int DEPTH = 200;
  localparam int PW    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [PW+1:0] din;
  logic          rx_valid, rx_ready, tx_valid, tx_ready, err_drop, err_clr;
  logic [DW-1:0] dout;

  always #5 clk = ~clk;

  cmd_ram_ctrl #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .MEM_DEPTH (DEPTH),
    .AUTO_INC  (1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .din      (din),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .dout     (dout),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .err_drop (err_drop),
    .err_clr  (err_clr)
  );

  // reference model state
  logic [7:0] m_mem [DEPTH];
  int         m_wr, m_rd;
  bit         m_pend, m_err;
  logic [7:0] m_dout;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock of stimulus; model advanced with the same rules the block must obey.
  task automatic cyc(input bit v, input logic [1:0] op, input logic [7:0] pay,
                     input bit txr, input bit clr);
    bit rdy, acc, drop, clamp;
    int a;
    rx_valid = v; din = {op, pay}; tx_ready = txr; err_clr = clr;
    #1;
    rdy = !(m_pend && !txr);
    chk("rx_ready", rx_ready, rdy);
    acc = v && rdy; drop = v && !rdy; clamp = 0;
    @(posedge clk);
    if (m_pend && txr) m_pend = 0;
    if (acc) begin
      case (op)
        2'd0: begin a = pay; if (a >= DEPTH) begin a = DEPTH - 1; clamp = 1; end m_wr = a; end
        2'd1: begin m_mem[m_wr] = pay; m_wr = (m_wr + 1) % DEPTH; end
        2'd2: begin a = pay; if (a >= DEPTH) begin a = DEPTH - 1; clamp = 1; end m_rd = a; end
        default: begin m_pend = 1; m_dout = m_mem[m_rd]; m_rd = (m_rd + 1) % DEPTH; end
      endcase
    end
    if (drop || clamp) m_err = 1;
    else if (clr)      m_err = 0;
    #1;
    chk("tx_valid", tx_valid, m_pend);
    if (m_pend) chk("dout", dout, m_dout);
    chk("err_drop", err_drop, m_err);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset();
    rx_valid = 0; err_clr = 0;
    #2;
    rst = 1;
    #1;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_err", err_drop, 1'b0);
    m_pend = 0; m_err = 0; m_wr = 0; m_rd = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1; rx_valid = 0; din = '0; tx_ready = 1; err_clr = 0;
    m_pend = 0; m_err = 0; m_wr = 0; m_rd = 0; m_dout = '0;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // fill memory so every later read has a known value
    cyc(1, 2'd0, 8'd0, 1, 0);
    for (int i = 0; i < DEPTH; i++) cyc(1, 2'd1, 8'($urandom), 1, 0);

    // reset then write/read back
    do_reset();
    cyc(1, 2'd0, 8'h10, 1, 0);
    cyc(1, 2'd1, 8'hA5, 1, 0);
    cyc(1, 2'd2, 8'h10, 1, 0);
    cyc(1, 2'd3, 8'h00, 1, 0);
    chk("t1_dout", dout, 8'hA5);
    chk("t1_err", err_drop, 1'b0);
    cyc(0, 2'd0, 8'h00, 1, 0);

    // burst with auto-increment, back-to-back reads
    cyc(1, 2'd0, 8'h00, 1, 0);
    cyc(1, 2'd1, 8'h11, 1, 0);
    cyc(1, 2'd1, 8'h22, 1, 0);
    cyc(1, 2'd1, 8'h33, 1, 0);
    cyc(1, 2'd2, 8'h00, 1, 0);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("burst0", dout, 8'h11);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("burst1", dout, 8'h22);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("burst2", dout, 8'h33);
    cyc(0, 2'd0, 8'h00, 1, 0);

    // wrap at last word, then clamped read address
    cyc(1, 2'd0, 8'd199, 1, 0);
    cyc(1, 2'd1, 8'h5A, 1, 0);
    cyc(1, 2'd1, 8'h6B, 1, 0);
    cyc(1, 2'd2, 8'd199, 1, 0);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("wrap_hi", dout, 8'h5A);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("wrap_lo", dout, 8'h6B);
    cyc(0, 2'd0, 8'h00, 1, 0);
    chk("err_pre_clamp", err_drop, 1'b0);
    cyc(1, 2'd2, 8'd250, 1, 0);
    chk("clamp_err", err_drop, 1'b1);
    cyc(1, 2'd3, 8'h00, 1, 0); chk("clamp_rd", dout, 8'h5A);
    cyc(0, 2'd0, 8'h00, 1, 1);
    chk("clr", err_drop, 1'b0);

    // backpressure: held word, dropped write, then release
    cyc(1, 2'd0, 8'd7, 1, 0);
    cyc(1, 2'd2, 8'd7, 1, 0);
    cyc(1, 2'd3, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cyc(0, 2'd0, 8'h00, 0, 0);
    cyc(1, 2'd1, 8'hEE, 0, 0);
    chk("bp_err", err_drop, 1'b1);
    cyc(0, 2'd0, 8'h00, 1, 0);
    cyc(1, 2'd2, 8'd7, 1, 0);
    cyc(1, 2'd3, 8'h00, 1, 0);
    cyc(0, 2'd0, 8'h00, 1, 1);

    // clear coinciding with a fresh drop: set wins
    cyc(1, 2'd3, 8'h00, 0, 0);
    cyc(1, 2'd1, 8'h44, 0, 1);
    chk("clr_vs_set", err_drop, 1'b1);
    cyc(0, 2'd0, 8'h00, 1, 0);

    // reset while a word is pending; memory survives
    cyc(1, 2'd2, 8'd42, 1, 0);
    cyc(1, 2'd3, 8'h00, 0, 0);
    do_reset();
    cyc(1, 2'd2, 8'd42, 1, 0);
    cyc(1, 2'd3, 8'h00, 1, 0);
    cyc(0, 2'd0, 8'h00, 1, 0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      cyc($urandom_range(0, 3) != 0, 2'($urandom), 8'($urandom),
          $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_ram_ctrl.md
Name: cmd_ram_ctrl

Overview:
- Parametrised, command-driven single-port RAM controller that sits behind the SPI slave's shift/decode logic.
- Each received word carries a 2-bit opcode plus payload: set write address, write data, set read address, or read data.
- Generalises the 8-bit controller:
  - independent data/address widths and depth;
  - optional address auto-increment for bursts;
  - full valid/ready handshake on both receive and transmit sides;
  - sticky error reporting for dropped commands.

Parameters:
- DATA_W, 8, memory word width in bits.
- ADDR_W, 8, address width in bits.
- MEM_DEPTH, 256, number of words; 2 <= MEM_DEPTH <= 2**ADDR_W; need not be a power of two.
- AUTO_INC, 1, 1 = read/write address pointers post-increment after each data access; 0 = pointers static.
- PAY_W, max(DATA_W,ADDR_W), payload width of din (derived; not to be overridden).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  PAY_W+2  [PAY_W+1:PAY_W] opcode, [PAY_W-1:0] payload.
- rx_valid  in  1  din valid this cycle.
- rx_ready  out  1  controller accepts din this cycle.
- dout  out  DATA_W  read data.
- tx_valid  out  1  dout valid; held until accepted.
- tx_ready  in  1  downstream accepts dout.
- err_drop  out  1  sticky: a command was offered while rx_ready=0.
- err_clr  in  1  synchronous clear of err_drop.

Behaviour:
- Reset (async assert, sync release):
  - dout=0, tx_valid=0, err_drop=0.
  - wr_ptr=0, rd_ptr=0.
  - Memory contents not reset.
  - Reset mid-read discards the pending word.
- Opcodes, acting on accept (rx_valid && rx_ready):
  - 00 = wr_ptr <= payload[ADDR_W-1:0].
  - 01 = mem[wr_ptr] <= payload[DATA_W-1:0].
  - 10 = rd_ptr <= payload[ADDR_W-1:0].
  - 11 = read mem[rd_ptr], payload ignored.
- Pointer range:
  - Address payloads >= MEM_DEPTH are clamped to MEM_DEPTH-1.
  - The clamp sets err_drop; the command is still executed.
- Auto-increment:
  - With AUTO_INC=1, the pointer increments after op 01 (wr_ptr) or op 11 (rd_ptr).
  - MEM_DEPTH-1 wraps to 0.
  - With AUTO_INC=0, the pointers never change except via op 00 and op 10.
- rx_ready = !(tx_valid && !tx_ready). All opcodes stall while a read word is pending and not being taken.
- Transmit FSM states:
  - IDLE: tx_valid=0. Accepting op 11 moves to PEND.
  - PEND: tx_valid=1, dout registered, one cycle after accept.
    - tx_ready=1 with no new op 11 accepted -> IDLE.
    - tx_ready=1 with a new op 11 accepted in the same cycle -> stay in PEND. The new word loads next cycle, giving back-to-back reads at 1 word/cycle.
    - tx_ready=0 -> hold dout and tx_valid stable.
- Latency:
  - Op 11 accepted at cycle N gives dout valid at N+1.
  - A write at N is visible to a read accepted at N+1.
- Dropped command:
  - Condition: rx_valid=1 && rx_ready=0.
  - The command has no effect; err_drop is set the next cycle.
  - err_drop stays set until an err_clr cycle.
  - If set and clear coincide, set wins.
- Unused payload MSBs (when DATA_W != ADDR_W) are ignored.

Decomposition:
- Package cmd_ram_pkg holds:
  - opcode localparams OP_WADDR=2'b00, OP_WDATA=2'b01, OP_RADDR=2'b10, OP_RDATA=2'b11;
  - FSM state encoding (IDLE, PEND);
  - the pointer wrap/clamp function.
- Sub-module sp_ram:
  - storage array with synchronous write and registered synchronous read;
  - parameters DATA_W, ADDR_W, MEM_DEPTH;
  - no reset.
- The controller owns the pointers, the FSM and the error flag.

Test Plan:
- Reset then write: rst pulse; op00 payload 0x10; op01 0xA5; op10 0x10; op11 -> dout=0xA5 with tx_valid one cycle after accept; err_drop=0.
- Burst with AUTO_INC=1: op00 0x00; op01 0x11, 0x22, 0x33; op10 0x00; op11 x3 with tx_ready=1 -> dout 0x11, 0x22, 0x33 on consecutive cycles.
- Wrap at MEM_DEPTH=200: op00 199; op01 0x5A; op01 0x6B -> mem[199]=0x5A, mem[0]=0x6B. Op10 250 -> rd_ptr=199, err_drop=1.
- Backpressure: op11 with tx_ready=0 for 4 cycles -> dout stable, rx_ready=0. Offer op01 during the stall -> memory unchanged, err_drop=1. tx_ready=1 -> rx_ready returns to 1.
- Async reset mid-read: assert rst between op11 accept and tx_ready -> tx_valid=0 and dout=0 immediately; memory retained (re-read returns old data).
- Error clear: err_drop=1, then err_clr=1 for 1 cycle -> err_drop=0. Clear coincident with a new drop -> err_drop stays 1.
